// File: rtl/load_store_unit.sv
// load_store_unit: RV32I M-stage load/store sequencer for a single-outstanding
// request/grant bus with a separate read-data return.
// Latency: zero-wait store done 2 cycles after acceptance, zero-wait load
// (gnt +1, rvalid +2) done at +3.
// Backpressure: o_lsu_stall holds the pipeline while a legal access is in
// REQ/WAIT; the bus request is held stable until i_bus_gnt or timeout.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_lsu_*               pipeline request (valid, we, funct3, addr, wdata)
//   o_lsu_rdata           extended load result, held until the next load
//   o_lsu_done/o_lsu_err  one-cycle completion / error pulses
//   o_lsu_stall           stall request into hazard logic
//   o_bus_*               registered bus request (req, we, addr, be, wdata)
//   i_bus_gnt/rvalid/rdata  bus grant and read-data return
module load_store_unit #(
  parameter logic [7:0] P_TIMEOUT = 8'd255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lsu_req,
  input  logic        i_lsu_we,
  input  logic [2:0]  i_lsu_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_done,
  output logic        o_lsu_err,
  output logic        o_lsu_stall,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        to_q, to_d;          // current transaction ended by timeout
  logic [31:0] rdata_q, rdata_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic        legal;
  logic        accept;
  logic        timeout;
  logic        busy;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] lane;
  logic [31:0] load_val;

  // Access legality: alignment per size, reserved funct3, and no unsigned stores.
  always_comb begin
    legal = 1'b0;
    case (i_lsu_funct3)
      3'd0:    legal = 1'b1;
      3'd1:    legal = ~i_lsu_addr[0];
      3'd2:    legal = (i_lsu_addr[1:0] == 2'b00);
      3'd4:    legal = ~i_lsu_we;
      3'd5:    legal = ~i_lsu_we & ~i_lsu_addr[0];
      default: legal = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated store data; loads share the enables.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = i_lsu_wdata;
    case (i_lsu_funct3[1:0])
      2'd0: begin
        be_new    = 4'b0001 << i_lsu_addr[1:0];
        wdata_new = {4{i_lsu_wdata[7:0]}};
      end
      2'd1: begin
        be_new    = 4'b0011 << i_lsu_addr[1:0];
        wdata_new = {2{i_lsu_wdata[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = i_lsu_wdata;
      end
    endcase
  end

  // Align the addressed lane to bit 0, then extend by access type.
  always_comb begin
    lane     = i_bus_rdata >> {off_q, 3'b000};
    load_val = lane;
    case (f3_q)
      3'd0:    load_val = {{24{lane[7]}}, lane[7:0]};
      3'd1:    load_val = {{16{lane[15]}}, lane[15:0]};
      3'd4:    load_val = {24'd0, lane[7:0]};
      3'd5:    load_val = {16'd0, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  // i_rst gating keeps the combinational paths from the request at 0 during reset.
  assign busy    = (state_q == S_REQ) || (state_q == S_WAIT);
  assign accept  = (state_q == S_IDLE) && i_lsu_req && legal && ~i_rst;
  assign timeout = busy && (cnt_q == P_TIMEOUT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        to_d = 1'b0;
        if (accept) begin
          state_d = S_REQ;
          cnt_d   = 8'd0;
        end
      end
      S_REQ: begin
        if (timeout) begin
          state_d = S_DONE;
          to_d    = 1'b1;
          rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (i_bus_gnt) begin
            if (we_q) begin
              state_d = S_DONE;
            end else if (i_bus_rvalid) begin
              rdata_d = load_val;
              state_d = S_DONE;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (timeout) begin
          state_d = S_DONE;
          to_d    = 1'b1;
          rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (i_bus_rvalid) begin
            rdata_d = load_val;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      to_q    <= 1'b0;
      rdata_q <= 32'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q    <= i_lsu_we;
        f3_q    <= i_lsu_funct3;
        off_q   <= i_lsu_addr[1:0];
        addr_q  <= {i_lsu_addr[31:2], 2'b00};
        be_q    <= be_new;
        wdata_q <= wdata_new;
      end
    end
  end

  assign o_lsu_rdata = rdata_q;
  assign o_lsu_done  = (state_q == S_DONE);
  assign o_lsu_err   = ((state_q == S_IDLE) && i_lsu_req && ~legal && ~i_rst) ||
                       ((state_q == S_DONE) && to_q);
  assign o_lsu_stall = busy || accept;
  // The request drops in the cycle the timeout is reached, before DONE.
  assign o_bus_req   = (state_q == S_REQ) && ~timeout;
  assign o_bus_we    = we_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_be    = be_q;
  assign o_bus_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit with a result
// scoreboard; expected load results/errors are queued at issue and popped
// on every o_lsu_done.
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_lsu_req;
  logic        i_lsu_we;
  logic [2:0]  i_lsu_funct3;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_lsu_wdata;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_done;
  logic        o_lsu_err;
  logic        o_lsu_stall;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_gnt;
  logic        i_bus_rvalid;
  logic [31:0] i_bus_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  always #5 i_clk = ~i_clk;

  load_store_unit #(.P_TIMEOUT(8'd4)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_lsu_req    (i_lsu_req),
    .i_lsu_we     (i_lsu_we),
    .i_lsu_funct3 (i_lsu_funct3),
    .i_lsu_addr   (i_lsu_addr),
    .i_lsu_wdata  (i_lsu_wdata),
    .o_lsu_rdata  (o_lsu_rdata),
    .o_lsu_done   (o_lsu_done),
    .o_lsu_err    (o_lsu_err),
    .o_lsu_stall  (o_lsu_stall),
    .o_bus_req    (o_bus_req),
    .o_bus_we     (o_bus_we),
    .o_bus_addr   (o_bus_addr),
    .o_bus_be     (o_bus_be),
    .o_bus_wdata  (o_bus_wdata),
    .i_bus_gnt    (i_bus_gnt),
    .i_bus_rvalid (i_bus_rvalid),
    .i_bus_rdata  (i_bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge i_clk);
    #1;
  endtask

  // Scoreboard consumer: every completion must match the oldest queued result.
  always @(negedge i_clk) begin
    if (!i_rst && o_lsu_done) begin
      chk("sb_has_entry", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_rdata", o_lsu_rdata, e.rdata);
        chk("sb_err", {31'd0, o_lsu_err}, {31'd0, e.err});
      end
    end
  end

  // Drive one legal access starting now (posedge+1); the bus grants at
  // gnt_at, returns data at rv_at, and a junk rvalid is driven at junk_at.
  task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int gnt_at, input int rv_at, input int junk_at,
                         input logic [31:0] bus_rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_done_at, output int req_hi);
    int done_c;
    exp_t e;
    done_c = -1;
    req_hi = 0;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb_q.push_back(e);
    i_lsu_req    = 1'b1;
    i_lsu_we     = we;
    i_lsu_funct3 = f3;
    i_lsu_addr   = addr;
    i_lsu_wdata  = wdata;
    for (int c = 0; c < 30 && done_c < 0; c++) begin
      i_bus_gnt    = (c == gnt_at);
      i_bus_rvalid = (c == rv_at) || (c == junk_at);
      i_bus_rdata  = (c == rv_at) ? bus_rdata : 32'hFFFF_FFFF;
      @(negedge i_clk);
      if (o_bus_req) req_hi++;
      if (c == gnt_at) begin
        chk({tag, "_bus_req"}, {31'd0, o_bus_req}, 32'd1);
        chk({tag, "_bus_we"}, {31'd0, o_bus_we}, {31'd0, we});
        chk({tag, "_bus_addr"}, o_bus_addr, {addr[31:2], 2'b00});
        chk({tag, "_bus_be"}, {28'd0, o_bus_be}, {28'd0, exp_be});
        if (we) chk({tag, "_bus_wdata"}, o_bus_wdata, exp_wdata);
      end
      chk({tag, "_stall"}, {31'd0, o_lsu_stall}, (c < exp_done_at) ? 32'd1 : 32'd0);
      if (o_lsu_done) begin
        done_c    = c;
        i_lsu_req = 1'b0;
      end
      nxt();
    end
    chk({tag, "_done_cycle"}, done_c, exp_done_at);
    i_lsu_req    = 1'b0;
    i_bus_gnt    = 1'b0;
    i_bus_rvalid = 1'b0;
  endtask

  // Illegal access: error pulse in the request cycle, no stall, no bus access.
  task automatic run_illegal(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr);
    i_lsu_req    = 1'b1;
    i_lsu_we     = we;
    i_lsu_funct3 = f3;
    i_lsu_addr   = addr;
    i_lsu_wdata  = 32'h5555_AAAA;
    @(negedge i_clk);
    chk({tag, "_err"}, {31'd0, o_lsu_err}, 32'd1);
    chk({tag, "_stall"}, {31'd0, o_lsu_stall}, 32'd0);
    chk({tag, "_bus_req0"}, {31'd0, o_bus_req}, 32'd0);
    nxt();
    i_lsu_req = 1'b0;
    @(negedge i_clk);
    chk({tag, "_err_gone"}, {31'd0, o_lsu_err}, 32'd0);
    chk({tag, "_bus_req1"}, {31'd0, o_bus_req}, 32'd0);
    nxt();
  endtask

  initial begin
    int rh;
    i_rst        = 1'b1;
    i_lsu_req    = 1'b1;   // legal request during reset must not stall
    i_lsu_we     = 1'b0;
    i_lsu_funct3 = 3'd2;
    i_lsu_addr   = 32'h0000_0100;
    i_lsu_wdata  = 32'd0;
    i_bus_gnt    = 1'b0;
    i_bus_rvalid = 1'b0;
    i_bus_rdata  = 32'd0;

    @(negedge i_clk);
    chk("rst_stall", {31'd0, o_lsu_stall}, 32'd0);
    chk("rst_err", {31'd0, o_lsu_err}, 32'd0);
    chk("rst_done", {31'd0, o_lsu_done}, 32'd0);
    chk("rst_bus_req", {31'd0, o_bus_req}, 32'd0);
    chk("rst_rdata", o_lsu_rdata, 32'd0);
    chk("rst_bus_addr", o_bus_addr, 32'd0);
    chk("rst_bus_be", {28'd0, o_bus_be}, 32'd0);
    nxt();
    i_lsu_req = 1'b0;
    i_rst     = 1'b0;
    nxt();

    // LB 0x1003: byte lane 3, sign-extended 0x80.
    run_txn("lb", 1'b0, 3'd0, 32'h0000_1003, 32'd0, 1, 2, -1, 32'h80FF_FF12,
            4'b1000, 32'd0, 32'hFFFF_FF80, 1'b0, 3, rh);
    // SH 0x2002 with a late grant; load result register holds.
    run_txn("sh", 1'b1, 3'd1, 32'h0000_2002, 32'h0000_BEEF, 3, -1, -1, 32'd0,
            4'b1100, 32'hBEEF_BEEF, 32'hFFFF_FF80, 1'b0, 4, rh);
    run_illegal("lw_mis", 1'b0, 3'd2, 32'h0000_3001);
    // LHU with grant and data in the same cycle.
    run_txn("lhu", 1'b0, 3'd5, 32'h0000_4000, 32'd0, 1, 1, -1, 32'h1234_F00D,
            4'b0011, 32'd0, 32'h0000_F00D, 1'b0, 2, rh);
    run_txn("sw", 1'b1, 3'd2, 32'h0000_5000, 32'hCAFE_0123, 1, -1, -1, 32'd0,
            4'b1111, 32'hCAFE_0123, 32'h0000_F00D, 1'b0, 2, rh);
    // LH upper half, two WAIT cycles.
    run_txn("lh", 1'b0, 3'd1, 32'h0000_6002, 32'd0, 1, 3, -1, 32'h8001_7FFF,
            4'b1100, 32'd0, 32'hFFFF_8001, 1'b0, 4, rh);
    run_txn("sb", 1'b1, 3'd0, 32'h0000_7001, 32'h0000_00A5, 2, -1, -1, 32'd0,
            4'b0010, 32'hA5A5_A5A5, 32'hFFFF_8001, 1'b0, 3, rh);
    run_illegal("lh_mis", 1'b0, 3'd1, 32'h0000_3003);
    run_illegal("f3_3", 1'b0, 3'd3, 32'h0000_3000);
    run_illegal("f3_6", 1'b0, 3'd6, 32'h0000_3000);
    run_illegal("st_f3_4", 1'b1, 3'd4, 32'h0000_3000);
    // Timeout: no grant ever; request high 4 cycles, then done+err with rdata 0.
    run_txn("tmo", 1'b0, 3'd2, 32'h0000_9000, 32'd0, -1, -1, 2, 32'd0,
            4'b1111, 32'd0, 32'd0, 1'b0 | 1'b1, 6, rh);
    chk("tmo_req_cycles", rh, 32'd4);
    // LBU with an rvalid before the grant that must be ignored.
    run_txn("lbu", 1'b0, 3'd4, 32'h0000_8002, 32'd0, 2, 3, 1, 32'h00C3_0000,
            4'b0100, 32'd0, 32'h0000_00C3, 1'b0, 4, rh);

    // Reset pulsed while the load sits in WAIT; late rvalid is ignored.
    i_lsu_req    = 1'b1;
    i_lsu_we     = 1'b0;
    i_lsu_funct3 = 3'd2;
    i_lsu_addr   = 32'h0000_A000;
    nxt();
    i_bus_gnt = 1'b1;
    @(negedge i_clk);
    chk("rstw_bus_req", {31'd0, o_bus_req}, 32'd1);
    nxt();
    i_bus_gnt = 1'b0;
    @(negedge i_clk);
    chk("rstw_wait_stall", {31'd0, o_lsu_stall}, 32'd1);
    #1;
    i_rst     = 1'b1;
    i_lsu_req = 1'b0;
    #1;
    chk("rstw_stall", {31'd0, o_lsu_stall}, 32'd0);
    chk("rstw_bus_req0", {31'd0, o_bus_req}, 32'd0);
    chk("rstw_rdata", o_lsu_rdata, 32'd0);
    chk("rstw_bus_be", {28'd0, o_bus_be}, 32'd0);
    nxt();
    i_rst = 1'b0;
    nxt();
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'h1234_5678;
    @(negedge i_clk);
    chk("rstw_late_done", {31'd0, o_lsu_done}, 32'd0);
    chk("rstw_late_stall", {31'd0, o_lsu_stall}, 32'd0);
    nxt();
    i_bus_rvalid = 1'b0;
    @(negedge i_clk);
    chk("rstw_after_done", {31'd0, o_lsu_done}, 32'd0);
    chk("rstw_after_rdata", o_lsu_rdata, 32'd0);
    nxt();

    // Normal load after reset recovery.
    run_txn("lw", 1'b0, 3'd2, 32'h0000_B000, 32'd0, 1, 2, -1, 32'h1357_9BDF,
            4'b1111, 32'd0, 32'h1357_9BDF, 1'b0, 3, rh);
    nxt();
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
